// File: rtl/sdram_port_arbiter_pkg.sv
// Shared SDRAM definitions: address/data widths and the client-port arbiter state.
//   SDRAM_ADDR_WIDTH  word address width of the SDRAM client port
//   SDRAM_DATA_WIDTH  data width of the SDRAM client port
//   sdram_arb_state_t IDLE / BUSY / DRAIN states of sdram_port_arbiter
package sdram_port_arbiter_pkg;

    localparam int unsigned SDRAM_ADDR_WIDTH = 21;
    localparam int unsigned SDRAM_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } sdram_arb_state_t;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter sharing one SDRAM controller client port.
// Requester 0 is the iomem path, requester 1 a secondary master (DMA/video).
// The winning request is registered onto mem_* and held until mem_ready;
// ready and read data are routed back to the winner only.
// Ports:
//   clk_logic, system_reset_n        clock, synchronous active-low reset
//   c0_*/c1_* addr,data,byte_en,wr,rd requester requests (strobes held until ready)
//   c0_q/c1_q, c0_ready/c1_ready     read data (= mem_q) and completion pulse
//   mem_addr,data,byte_en,wr,rd      registered request to the SDRAM controller
//   mem_q, mem_ready                 controller read data and completion pulse
//   grant                            current or last granted requester (debug)
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = SDRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = SDRAM_DATA_WIDTH,
    parameter bit          FIXED_PRIORITY = 1'b0
) (
    input  logic                      clk_logic,
    input  logic                      system_reset_n,

    input  logic [ADDR_WIDTH-1:0]     c0_addr,
    input  logic [DATA_WIDTH-1:0]     c0_data,
    input  logic [DATA_WIDTH/8-1:0]   c0_byte_en,
    input  logic                      c0_wr,
    input  logic                      c0_rd,
    output logic [DATA_WIDTH-1:0]     c0_q,
    output logic                      c0_ready,

    input  logic [ADDR_WIDTH-1:0]     c1_addr,
    input  logic [DATA_WIDTH-1:0]     c1_data,
    input  logic [DATA_WIDTH/8-1:0]   c1_byte_en,
    input  logic                      c1_wr,
    input  logic                      c1_rd,
    output logic [DATA_WIDTH-1:0]     c1_q,
    output logic                      c1_ready,

    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_data,
    output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
    output logic                      mem_wr,
    output logic                      mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_q,
    input  logic                      mem_ready,

    output logic                      grant
);

    sdram_arb_state_t              state;
    logic                          last_grant;

    logic                          req0;
    logic                          req1;
    logic                          pick;
    logic [ADDR_WIDTH-1:0]         sel_addr;
    logic [DATA_WIDTH-1:0]         sel_data;
    logic [DATA_WIDTH/8-1:0]       sel_byte_en;
    logic                          sel_wr;
    logic                          sel_rd;

    // Grant decision and winner's request fields, evaluated every cycle but only used in IDLE.
    always_comb begin
        req0 = c0_wr | c0_rd;
        req1 = c1_wr | c1_rd;
        if (req0 && req1) begin
            pick = FIXED_PRIORITY ? 1'b0 : ~last_grant;
        end else begin
            pick = req1;
        end
        sel_addr    = pick ? c1_addr    : c0_addr;
        sel_data    = pick ? c1_data    : c0_data;
        sel_byte_en = pick ? c1_byte_en : c0_byte_en;
        sel_wr      = pick ? c1_wr      : c0_wr;
        sel_rd      = pick ? c1_rd      : c0_rd;
    end

    // Arbiter FSM with registered downstream request.
    always_ff @(posedge clk_logic) begin
        if (!system_reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b0;
            grant       <= 1'b0;
            mem_addr    <= '0;
            mem_data    <= '0;
            mem_byte_en <= '0;
            mem_wr      <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        grant       <= pick;
                        mem_addr    <= sel_addr;
                        mem_data    <= sel_data;
                        mem_byte_en <= sel_byte_en;
                        // A simultaneous wr and rd is treated as a write.
                        mem_wr      <= sel_wr;
                        mem_rd      <= sel_rd & ~sel_wr;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_wr     <= 1'b0;
                        mem_rd     <= 1'b0;
                        last_grant <= grant;
                        state      <= DRAIN;
                    end
                end
                // One-cycle gap so the winner can drop its strobe before re-arbitration.
                DRAIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign c0_q     = mem_q;
    assign c1_q     = mem_q;
    assign c0_ready = mem_ready & (state == BUSY) & ~grant;
    assign c1_ready = mem_ready & (state == BUSY) &  grant;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: a round-robin instance (dut) and
// a fixed-priority instance (dut_fp) sharing address/data inputs.
module tb_sdram_port_arbiter;

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          clk_logic = 1'b0;
    logic          system_reset_n;

    logic [AW-1:0] c0_addr, c1_addr;
    logic [DW-1:0] c0_data, c1_data;
    logic [BW-1:0] c0_byte_en, c1_byte_en;
    logic          c0_wr, c0_rd, c1_wr, c1_rd;
    logic [DW-1:0] mem_q;
    logic          mem_ready;

    logic [DW-1:0] c0_q, c1_q;
    logic          c0_ready, c1_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [BW-1:0] mem_byte_en;
    logic          mem_wr, mem_rd, grant;

    logic          fc0_wr, fc0_rd, fc1_wr, fc1_rd, fmem_ready;
    logic [DW-1:0] f_c0_q, f_c1_q;
    logic          f_c0_ready, f_c1_ready;
    logic [AW-1:0] f_mem_addr;
    logic [DW-1:0] f_mem_data;
    logic [BW-1:0] f_mem_byte_en;
    logic          f_mem_wr, f_mem_rd, f_grant;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_logic = ~clk_logic;

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b0)) dut (
        .clk_logic(clk_logic), .system_reset_n(system_reset_n),
        .c0_addr(c0_addr), .c0_data(c0_data), .c0_byte_en(c0_byte_en),
        .c0_wr(c0_wr), .c0_rd(c0_rd), .c0_q(c0_q), .c0_ready(c0_ready),
        .c1_addr(c1_addr), .c1_data(c1_data), .c1_byte_en(c1_byte_en),
        .c1_wr(c1_wr), .c1_rd(c1_rd), .c1_q(c1_q), .c1_ready(c1_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_byte_en(mem_byte_en),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_q(mem_q), .mem_ready(mem_ready),
        .grant(grant)
    );

    sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b1)) dut_fp (
        .clk_logic(clk_logic), .system_reset_n(system_reset_n),
        .c0_addr(c0_addr), .c0_data(c0_data), .c0_byte_en(c0_byte_en),
        .c0_wr(fc0_wr), .c0_rd(fc0_rd), .c0_q(f_c0_q), .c0_ready(f_c0_ready),
        .c1_addr(c1_addr), .c1_data(c1_data), .c1_byte_en(c1_byte_en),
        .c1_wr(fc1_wr), .c1_rd(fc1_rd), .c1_q(f_c1_q), .c1_ready(f_c1_ready),
        .mem_addr(f_mem_addr), .mem_data(f_mem_data), .mem_byte_en(f_mem_byte_en),
        .mem_wr(f_mem_wr), .mem_rd(f_mem_rd), .mem_q(mem_q), .mem_ready(fmem_ready),
        .grant(f_grant)
    );

    typedef struct packed {
        logic c0_wr, c0_rd, c1_wr, c1_rd;
        logic exp_busy, exp_wr, exp_rd, exp_grant;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_logic);
        @(negedge clk_logic);
    endtask

    // Pulse mem_ready for one cycle in BUSY; returns at the negedge in DRAIN.
    task automatic complete(input bit fp, input bit exp0, input bit exp1, input logic [DW-1:0] q);
        mem_q = q;
        if (fp) fmem_ready = 1'b1; else mem_ready = 1'b1;
        #1;
        chk("c0_ready", fp ? f_c0_ready : c0_ready, exp0);
        chk("c1_ready", fp ? f_c1_ready : c1_ready, exp1);
        if (exp0) chk("c0_q", fp ? f_c0_q : c0_q, q);
        if (exp1) chk("c1_q", fp ? f_c1_q : c1_q, q);
        tick();
        mem_ready  = 1'b0;
        fmem_ready = 1'b0;
        chk("drain_wr", fp ? f_mem_wr : mem_wr, 1'b0);
        chk("drain_rd", fp ? f_mem_rd : mem_rd, 1'b0);
        chk("drain_no_ready", fp ? (f_c0_ready | f_c1_ready) : (c0_ready | c1_ready), 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        system_reset_n = 1'b0;
        c0_addr = '0; c1_addr = '0; c0_data = '0; c1_data = '0;
        c0_byte_en = '0; c1_byte_en = '0;
        c0_wr = 0; c0_rd = 0; c1_wr = 0; c1_rd = 0;
        fc0_wr = 0; fc0_rd = 0; fc1_wr = 0; fc1_rd = 0;
        mem_q = '0; mem_ready = 1'b0; fmem_ready = 1'b0;

        // Reset state; mem_ready high in IDLE must not produce a client ready.
        repeat (3) tick();
        mem_ready = 1'b1;
        #1;
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_mem_data", mem_data, '0);
        chk("rst_mem_be", mem_byte_en, '0);
        chk("rst_ready", {c0_ready, c1_ready}, 2'b00);
        mem_ready = 1'b0;
        system_reset_n = 1'b1;
        tick();

        // {c0_wr,c0_rd,c1_wr,c1_rd, busy,wr,rd,grant}; round-robin pointer starts at 0.
        vecs[0] = '{0,0,0,0, 0,0,0,0};
        vecs[1] = '{0,1,0,0, 1,0,1,0};
        vecs[2] = '{0,0,1,0, 1,1,0,1};
        vecs[3] = '{0,1,0,1, 1,0,1,0};
        vecs[4] = '{0,1,0,1, 1,0,1,1};
        vecs[5] = '{1,1,0,0, 1,1,0,0};
        vecs[6] = '{1,0,1,1, 1,1,0,1};
        vecs[7] = '{0,0,0,0, 0,0,0,1};

        c0_addr = 21'h00010; c0_data = 32'h11111111; c0_byte_en = 4'hF;
        c1_addr = 21'h00020; c1_data = 32'h22222222; c1_byte_en = 4'h3;
        for (int i = 0; i < 8; i++) begin
            c0_wr = vecs[i].c0_wr; c0_rd = vecs[i].c0_rd;
            c1_wr = vecs[i].c1_wr; c1_rd = vecs[i].c1_rd;
            tick();
            chk($sformatf("v%0d_mem_wr", i), mem_wr, vecs[i].exp_wr);
            chk($sformatf("v%0d_mem_rd", i), mem_rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_grant", i), grant, vecs[i].exp_grant);
            if (vecs[i].exp_busy) begin
                chk($sformatf("v%0d_mem_addr", i), mem_addr,
                    vecs[i].exp_grant ? 21'h00020 : 21'h00010);
                chk($sformatf("v%0d_mem_data", i), mem_data,
                    vecs[i].exp_grant ? 32'h22222222 : 32'h11111111);
                complete(1'b0, !vecs[i].exp_grant, vecs[i].exp_grant, 32'h1000 + i);
                c0_wr = 0; c0_rd = 0; c1_wr = 0; c1_rd = 0;
                tick();
            end
        end

        // Single read by requester 0, controller answers 5 cycles after the grant.
        c0_addr = 21'h00123; c0_rd = 1'b1;
        tick();
        chk("rd_mem_rd", mem_rd, 1'b1);
        chk("rd_grant", grant, 1'b0);
        chk("rd_mem_addr", mem_addr, 21'h00123);
        repeat (4) tick();
        chk("rd_hold", {mem_rd, mem_wr}, 2'b10);
        complete(1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        c0_rd = 1'b0;
        tick();

        // Write latch: requester 1 changes its data mid-BUSY.
        c1_wr = 1'b1; c1_byte_en = 4'b0011; c1_data = 32'h0000A5A5;
        tick();
        chk("wr_mem_wr", mem_wr, 1'b1);
        chk("wr_grant", grant, 1'b1);
        chk("wr_mem_be", mem_byte_en, 4'b0011);
        c1_data = 32'hFFFFFFFF;
        repeat (2) tick();
        chk("wr_data_held", mem_data, 32'h0000A5A5);
        complete(1'b0, 1'b0, 1'b1, 32'h0);
        c1_wr = 1'b0;
        tick();

        // Round-robin contention; last winner is requester 1, so grants go 0,1,0,1.
        c0_addr = 21'h00AAA; c1_addr = 21'h00BBB;
        c0_rd = 1'b1; c1_rd = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d_grant", k), grant, k[0]);
            chk($sformatf("rr%0d_addr", k), mem_addr, k[0] ? 21'h00BBB : 21'h00AAA);
            complete(1'b0, !k[0], k[0], 32'h5000 + k);
            if (k == 3) begin c0_rd = 1'b0; c1_rd = 1'b0; end
            tick();
            chk($sformatf("rr%0d_idle_gap", k), mem_rd, 1'b0);
        end

        // Abandon: requester 0 drops its strobe in BUSY; transaction still completes.
        c0_rd = 1'b1;
        tick();
        chk("ab_grant", grant, 1'b0);
        c0_rd = 1'b0;
        tick();
        chk("ab_held", mem_rd, 1'b1);
        complete(1'b0, 1'b1, 1'b0, 32'h0BAD0BAD);
        tick();
        tick();
        chk("ab_no_regrant", {mem_rd, mem_wr}, 2'b00);

        // Reset while BUSY, then a stray mem_ready.
        c1_rd = 1'b1;
        tick();
        chk("rb_grant", grant, 1'b1);
        chk("rb_mem_rd", mem_rd, 1'b1);
        system_reset_n = 1'b0;
        c1_rd = 1'b0;
        tick();
        chk("rb_mem_rd_clr", mem_rd, 1'b0);
        chk("rb_grant_clr", grant, 1'b0);
        system_reset_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("rb_stray_ready", {c0_ready, c1_ready}, 2'b00);
        tick();
        mem_ready = 1'b0;
        chk("rb_still_idle", mem_rd, 1'b0);

        // Fixed priority: requester 0 wins each contention; 1 wins only once 0 is idle.
        fc0_rd = 1'b1; fc1_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("fp%0d_grant", k), f_grant, 1'b0);
            chk($sformatf("fp%0d_rd", k), f_mem_rd, 1'b1);
            complete(1'b1, 1'b1, 1'b0, 32'h7000 + k);
            if (k == 2) fc0_rd = 1'b0;
            tick();
        end
        tick();
        chk("fp_c1_grant", f_grant, 1'b1);
        chk("fp_c1_addr", f_mem_addr, 21'h00BBB);
        complete(1'b1, 1'b0, 1'b1, 32'h7777);
        fc1_rd = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
